// File: rtl/neg_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// neg_share_arbiter_pkg : shared constants and helpers for neg_share_arbiter
// Revision: 1.0
// ============================================================================
package neg_share_arbiter_pkg;

  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] MIN_NEG = 64'h8000_0000_0000_0000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neg_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin grant, searching upward from rr_ptr
// Revision: 1.0
// ============================================================================
module rr_arbiter
  import neg_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  always_comb begin
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    // Outer loop walks priority order; inner loop keeps every bit select constant.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/negator.sv
`default_nettype none
// ============================================================================
// negator : two's-complement negation datapath, result = -operand (mod 2^W)
// Revision: 1.0
// ============================================================================
module negator #(
  parameter int W = 64
) (
  input  logic [W-1:0] operand,
  output logic [W-1:0] result
);

  assign result = -operand;

endmodule
`default_nettype wire

// File: rtl/neg_share_arbiter.sv
`default_nettype none
// ============================================================================
// neg_share_arbiter : round-robin sharing of one negator, registered response.
// Optional NEG_SHARE_ARBITER_OVF_EN adds resp_ovf (operand was MIN_NEG).
// Revision: 1.0
// ============================================================================
module neg_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  input  logic                      resp_ready,
  output logic                      busy
`ifdef NEG_SHARE_ARBITER_OVF_EN
  ,
  output logic                      resp_ovf
`endif
);

  import neg_share_arbiter_pkg::*;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W-1:0]    w_next_ptr;
  logic               w_out_free;
  logic               w_accept;
  logic [DATA_W-1:0]  w_sel_data;
  logic [DATA_W-1:0]  w_neg_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  negator #(
    .W (DATA_W)
  ) u_negator (
    .operand (w_sel_data),
    .result  (w_neg_data)
  );

  assign w_out_free = !resp_valid || resp_ready;
  // Gate with rst_n so nothing is acknowledged while the block is held in reset.
  assign req_ready  = (rst_n && w_out_free) ? w_grant : '0;
  assign w_accept   = |(req_valid & req_ready);
  assign w_sel_data = req_data[int'(w_grant_idx) * DATA_W +: DATA_W];
  assign w_next_ptr = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
  assign busy       = resp_valid || (|req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      r_rr_ptr   <= '0;
    end else if (w_accept) begin
      resp_valid <= 1'b1;
      resp_data  <= w_neg_data;
      resp_id    <= w_grant_idx;
      r_rr_ptr   <= w_next_ptr;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef NEG_SHARE_ARBITER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_ovf <= 1'b0;
    end else if (w_accept) begin
      resp_ovf <= (w_sel_data == MIN_NEG);
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/neg_share_arbiter.md
Name: neg_share_arbiter

Overview:
- Shares one 64-bit two's-complement negator (existing `negator` datapath, out = -in) between NUM_REQ requesters in the ALU.
- Round-robin arbitration with valid/ready on each request port.
- Single registered response port tagged with the winning requester's index.
- One-stage pipeline: full throughput of 1 result/cycle when the consumer is always ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 64, operand/result width; fixed to match the negator.
- ID_W, 2, width of resp_id; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_data  input  NUM_REQ*DATA_W  flattened operands; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester accept (combinational).
- resp_valid  output  1  result register holds a valid result.
- resp_data  output  DATA_W  negated operand.
- resp_id  output  ID_W  index of the requester that produced resp_data.
- resp_ready  input  1  consumer accepts the result.
- busy  output  1  resp_valid OR any req_valid (combinational).

Interface (already decided):
- One clock.
- Reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous): resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0. req_ready=0 throughout reset.
- out_free = !resp_valid || resp_ready.
- Grant is one-hot:
  - Pick the first requester with req_valid=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - No valid requester gives grant=0.
- req_ready[i] = grant[i] && out_free. At most one bit is high.
- Accept = |(req_valid & req_ready). On accept, next edge:
  - resp_data <= -req_data[g], taken through the negator instance.
  - resp_id <= g.
  - resp_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- No accept and resp_ready=1: resp_valid <= 0. resp_data and resp_id hold their stale values.
- No accept and resp_ready=0: all state holds. The result stays stable until consumed; no drop, no overwrite.
- Simultaneous consume and accept: the new result replaces the old one in the same edge. No bubble.
- Latency: 1 cycle from accept to resp_valid.
- Arithmetic is modulo 2^64:
  - -0 = 0.
  - -0x8000_0000_0000_0000 = 0x8000_0000_0000_0000.
- rr_ptr advances only on accept. An idle cycle does not rotate priority.
- Requesters must hold req_valid and req_data stable until accepted; the block does not check this.
- Reset mid-operation: a pending result is discarded and resp_valid drops immediately (asynchronously).
- Starvation bound: a requester holding valid is granted within NUM_REQ accepts.

Optional Feature:
- Macro: NEG_SHARE_ARBITER_OVF_EN.
- Defined:
  - Adds output resp_ovf (1 bit), registered alongside resp_data.
  - resp_ovf = 1 when the accepted operand equals 0x8000_0000_0000_0000.
  - Reset value 0; holds with resp_data.
- Undefined: port and register absent; behaviour otherwise identical.

Decomposition:
- Shared header/package:
  - DATA_W=64.
  - MIN_NEG constant 64'h8000_0000_0000_0000.
  - clog2 helper function.
- Natural sub-module: rr_arbiter.
  - Parameter NUM_REQ.
  - Inputs req and rr_ptr; outputs grant one-hot and grant_idx.
  - Purely combinational.
- The top holds rr_ptr, the result register and the negator instance.

Test Plan:
1. Reset then idle, all valid=0: resp_valid=0, busy=0, rr_ptr=0; req_ready=0 while rst_n=0.
2. Requester 2 alone sends 0x0000_0000_0000_0005, resp_ready=1: next cycle resp_valid=1, resp_data=0xFFFF_FFFF_FFFF_FFFB, resp_id=2.
3. All four valid, resp_ready=1, from reset: grant order 0,1,2,3,0 on consecutive cycles, one result per cycle, no bubbles.
4. Backpressure:
   - resp_ready=0 while holding result for id 1 (data 0xAAAA_AAAA_AAAA_AAAA negated = 0x5555_5555_5555_5556).
   - Other requests stay valid: req_ready=0 for all, result stable for 5 cycles.
   - Release: next grant goes to id 2.
5. Edge operands:
   - 0 gives 0.
   - 0xFFFF_FFFF_FFFF_FFFF gives 0x0000_0000_0000_0001.
   - 0x8000_0000_0000_0000 gives itself, with resp_ovf=1 when NEG_SHARE_ARBITER_OVF_EN is defined.
6. Assert rst_n=0 mid-stream with resp_valid=1 and resp_ready=0: resp_valid drops without waiting for clk; after release, the first grant goes to the lowest valid index (rr_ptr=0).
